// File: rtl/bp_fe_bht_updater.sv
// In-order prediction-tracking queue that turns branch resolutions into BHT updates.
// Optional mispredict counter enabled by defining BP_FE_BHT_UPDATER_STATS_EN.
module bp_fe_bht_updater #(
  parameter bht_idx_width_p = "inv",
  parameter int els_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  output logic                       res_ready_o,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [15:0]                mispredict_cnt_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  logic [bht_idx_width_p-1:0] idx_mem_q [els_p];
  logic [bht_idx_width_p-1:0] idx_mem_d [els_p];
  logic [els_p-1:0]           taken_mem_q, taken_mem_d;
  logic [ptr_w_lp-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0]        count_q, count_d;
  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
  logic                       correct_q, correct_d;
  logic                       enq, deq, mispredict;

  // Ready flags come from registered occupancy only, so a same-cycle dequeue never frees a slot.
  assign pred_ready_o = (count_q != cnt_w_lp'(els_p));
  assign res_ready_o  = (count_q != '0);
  assign enq          = pred_v_i & pred_ready_o & ~flush_i;
  assign deq          = res_v_i & res_ready_o;
  assign mispredict   = deq & (taken_mem_q[rptr_q] != res_taken_i);

  always_comb begin
    idx_mem_d   = idx_mem_q;
    taken_mem_d = taken_mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    w_v_d       = deq;
    idx_w_d     = idx_w_q;
    correct_d   = correct_q;
    if (enq) begin
      idx_mem_d[wptr_q]   = pred_idx_i;
      taken_mem_d[wptr_q] = pred_taken_i;
      wptr_d              = wptr_q + 1'b1;
    end
    if (deq) begin
      idx_w_d   = idx_mem_q[rptr_q];
      correct_d = ~mispredict;
      rptr_d    = rptr_q + 1'b1;
    end
    // Flush empties the queue but the head resolution above still produces its update.
    if (flush_i) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      w_v_q     <= 1'b0;
      idx_w_q   <= '0;
      correct_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      w_v_q     <= w_v_d;
      idx_w_q   <= idx_w_d;
      correct_q <= correct_d;
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    idx_mem_q   <= idx_mem_d;
    taken_mem_q <= taken_mem_d;
  end

  assign w_v_o     = w_v_q;
  assign idx_w_o   = idx_w_q;
  assign correct_o = correct_q;

`ifdef BP_FE_BHT_UPDATER_STATS_EN
  logic [15:0] mcnt_q, mcnt_d;

  always_comb begin
    mcnt_d = mcnt_q;
    if (mispredict && (mcnt_q != 16'hFFFF)) mcnt_d = mcnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) mcnt_q <= '0;
    else         mcnt_q <= mcnt_d;
  end

  assign mispredict_cnt_o = mcnt_q;
`else
  assign mispredict_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_bp_fe_bht_updater.sv
// Directed bench for bp_fe_bht_updater: queue-level reference model checked every cycle
// plus literal expectations for the key scenarios.
module tb_bp_fe_bht_updater;

  localparam int W   = 6;
  localparam int ELS = 8;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         pred_v_i = 1'b0;
  logic [W-1:0] pred_idx_i = '0;
  logic         pred_taken_i = 1'b0;
  logic         pred_ready_o;
  logic         res_v_i = 1'b0;
  logic         res_taken_i = 1'b0;
  logic         res_ready_o;
  logic         flush_i = 1'b0;
  logic         w_v_o;
  logic [W-1:0] idx_w_o;
  logic         correct_o;
  logic [15:0]  mispredict_cnt_o;

  bp_fe_bht_updater #(.bht_idx_width_p(W), .els_p(ELS)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
    .pred_ready_o(pred_ready_o),
    .res_v_i(res_v_i), .res_taken_i(res_taken_i), .res_ready_o(res_ready_o),
    .flush_i(flush_i),
    .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: queue of {idx, taken}
  logic [W:0]   exp_q[$];
  logic         m_started = 1'b0;
  logic         m_w_v = 1'b0;
  logic [W-1:0] m_idx = '0;
  logic         m_correct = 1'b0;
  logic [15:0]  m_cnt = '0;
`ifdef BP_FE_BHT_UPDATER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always @(posedge clk) begin
    if (reset_i) begin
      exp_q.delete();
      m_w_v = 1'b0; m_idx = '0; m_correct = 1'b0; m_cnt = '0;
      m_started = 1'b1;
    end else if (m_started) begin
      logic can_push;
      logic [W:0] e;
      can_push = (exp_q.size() != ELS);
      m_w_v = 1'b0;
      if (res_v_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        m_w_v = 1'b1;
        m_idx = e[W:1];
        m_correct = (e[0] == res_taken_i);
        if (STATS && !m_correct && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (flush_i) exp_q.delete();
      else if (pred_v_i && can_push) exp_q.push_back({pred_idx_i, pred_taken_i});
    end
  end

  // literal expectations posted by the driver, checked at the next falling edge
  typedef struct {
    string       name;
    int          sel;
    logic [15:0] val;
  } lit_t;
  lit_t lit_q[$];

  localparam int S_WV = 0, S_IDX = 1, S_COR = 2, S_PRDY = 3, S_RRDY = 4, S_CNT = 5;

  function automatic logic [15:0] dut_out(input int sel);
    case (sel)
      S_WV:    return {15'd0, w_v_o};
      S_IDX:   return {10'd0, idx_w_o};
      S_COR:   return {15'd0, correct_o};
      S_PRDY:  return {15'd0, pred_ready_o};
      S_RRDY:  return {15'd0, res_ready_o};
      default: return mispredict_cnt_o;
    endcase
  endfunction

  // scoreboard: the only writer of the counters
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started && !reset_i) begin
      chk("pred_ready", {15'd0, pred_ready_o}, {15'd0, exp_q.size() != ELS});
      chk("res_ready",  {15'd0, res_ready_o},  {15'd0, exp_q.size() != 0});
      chk("w_v",        {15'd0, w_v_o},        {15'd0, m_w_v});
      chk("idx_w",      {10'd0, idx_w_o},      {10'd0, m_idx});
      chk("correct",    {15'd0, correct_o},    {15'd0, m_correct});
      chk("mispredict_cnt", mispredict_cnt_o, m_cnt);
    end
    while (lit_q.size() != 0) begin
      lit_t l;
      l = lit_q.pop_front();
      chk(l.name, dut_out(l.sel), l.val);
    end
  end

  // driver
  task automatic step(input logic pv, input logic [W-1:0] pidx, input logic pt,
                      input logic rv, input logic rt, input logic fl, input logic rst);
    pred_v_i = pv; pred_idx_i = pidx; pred_taken_i = pt;
    res_v_i = rv; res_taken_i = rt; flush_i = fl; reset_i = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enq(input logic [W-1:0] idx, input logic t);
    step(1'b1, idx, t, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic res(input logic rt);
    step(1'b0, '0, 1'b0, 1'b1, rt, 1'b0, 1'b0);
  endtask

  task automatic expect_lit(input string nm, input int sel, input logic [15:0] val);
    lit_t l;
    l.name = nm; l.sel = sel; l.val = val;
    lit_q.push_back(l);
  endtask

  initial begin
    // reset state
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    expect_lit("rst_w_v", S_WV, 16'd0);
    expect_lit("rst_idx", S_IDX, 16'd0);
    expect_lit("rst_cor", S_COR, 16'd0);
    expect_lit("rst_prdy", S_PRDY, 16'd1);
    expect_lit("rst_rrdy", S_RRDY, 16'd0);
    expect_lit("rst_cnt", S_CNT, 16'd0);

    // single prediction, correct
    enq(6'd5, 1'b1);
    expect_lit("one_rrdy", S_RRDY, 16'd1);
    res(1'b1);
    expect_lit("one_w_v", S_WV, 16'd1);
    expect_lit("one_idx", S_IDX, 16'd5);
    expect_lit("one_cor", S_COR, 16'd1);
    idle();
    expect_lit("one_w_v_drop", S_WV, 16'd0);
    expect_lit("one_idx_hold", S_IDX, 16'd5);

    // in-order resolution
    enq(6'd1, 1'b0); enq(6'd2, 1'b1); enq(6'd3, 1'b0);
    res(1'b0);
    expect_lit("ord1_idx", S_IDX, 16'd1); expect_lit("ord1_cor", S_COR, 16'd1);
    res(1'b0);
    expect_lit("ord2_idx", S_IDX, 16'd2); expect_lit("ord2_cor", S_COR, 16'd0);
    res(1'b0);
    expect_lit("ord3_idx", S_IDX, 16'd3); expect_lit("ord3_cor", S_COR, 16'd1);
    expect_lit("ord3_w_v", S_WV, 16'd1);
    idle();

    // fill, drop while full, full with simultaneous dequeue
    for (int i = 0; i < ELS; i++) enq(W'(8 + i), i[0]);
    expect_lit("full_prdy", S_PRDY, 16'd0);
    enq(6'd30, 1'b1);
    expect_lit("drop_prdy", S_PRDY, 16'd0);
    step(1'b1, 6'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_lit("fullres_w_v", S_WV, 16'd1);
    expect_lit("fullres_idx", S_IDX, 16'd8);
    expect_lit("fullres_prdy", S_PRDY, 16'd1);
    for (int i = 1; i < ELS; i++) begin
      res(1'b1);
      expect_lit("drain_idx", S_IDX, 16'(8 + i));
      expect_lit("drain_cor", S_COR, {15'd0, i[0]});
    end
    expect_lit("drained_rrdy", S_RRDY, 16'd0);

    // resolution on empty queue
    res(1'b1);
    expect_lit("empty_w_v", S_WV, 16'd0);
    expect_lit("empty_rrdy", S_RRDY, 16'd0);
    idle();

    // flush with same-cycle resolution and prediction
    enq(6'd20, 1'b1); enq(6'd21, 1'b0); enq(6'd22, 1'b1);
    step(1'b1, 6'd23, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_lit("flush_w_v", S_WV, 16'd1);
    expect_lit("flush_idx", S_IDX, 16'd20);
    expect_lit("flush_cor", S_COR, 16'd1);
    expect_lit("flush_rrdy", S_RRDY, 16'd0);
    idle();
    expect_lit("flush_after_w_v", S_WV, 16'd0);
    expect_lit("flush_after_rrdy", S_RRDY, 16'd0);

    // simultaneous enqueue and dequeue, pointers wrap past the flush restart
    enq(6'd40, 1'b0);
    step(1'b1, 6'd41, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_lit("sim1_idx", S_IDX, 16'd40);
    step(1'b1, 6'd42, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_lit("sim2_idx", S_IDX, 16'd41); expect_lit("sim2_cor", S_COR, 16'd0);
    res(1'b0);
    expect_lit("sim3_idx", S_IDX, 16'd42); expect_lit("sim3_rrdy", S_RRDY, 16'd0);

    // mispredict statistic, then reset mid-stream with a live resolution
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    enq(6'd50, 1'b1); enq(6'd51, 1'b1); enq(6'd52, 1'b1);
    res(1'b0); res(1'b0); res(1'b0);
    expect_lit("stat_cnt", S_CNT, STATS ? 16'd3 : 16'd0);
    enq(6'd53, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_lit("rst_mid_w_v", S_WV, 16'd0);
    expect_lit("rst_mid_cnt", S_CNT, 16'd0);
    expect_lit("rst_mid_rrdy", S_RRDY, 16'd0);
    expect_lit("rst_mid_idx", S_IDX, 16'd0);
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_updater.md
BP_FE_BHT_UPDATER -- requirements
Module: bp_fe_bht_updater

Interface
REQ-001 SHALL have parameter bht_idx_width_p, default "inv": BHT index width, matching the BHT it drives.
REQ-002 SHALL have parameter els_p, default 8: prediction-tracking queue depth; power of 2, >= 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pred_v_i, input, 1 bit: a prediction was issued this cycle.
REQ-006 SHALL have port pred_idx_i, input, bht_idx_width_p bits: BHT index used for that prediction.
REQ-007 SHALL have port pred_taken_i, input, 1 bit: predicted direction.
REQ-008 SHALL have port pred_ready_o, output, 1 bit: queue can accept a prediction.
REQ-009 SHALL have port res_v_i, input, 1 bit: the oldest outstanding branch has resolved.
REQ-010 SHALL have port res_taken_i, input, 1 bit: actual resolved direction.
REQ-011 SHALL have port res_ready_o, output, 1 bit: queue holds at least one entry.
REQ-012 SHALL have port flush_i, input, 1 bit: discard all outstanding predictions.
REQ-013 SHALL have port w_v_o, output, 1 bit: BHT update valid.
REQ-014 SHALL have port idx_w_o, output, bht_idx_width_p bits: BHT index to update.
REQ-015 SHALL have port correct_o, output, 1 bit: the prediction was correct.
REQ-016 SHALL have port mispredict_cnt_o, output, 16 bits: mispredict statistic (see Configuration).

Function
REQ-017 SHALL keep an in-order FIFO of {idx, taken} entries with an occupancy count of width $clog2(els_p)+1; pointers wrap modulo els_p.
REQ-018 SHALL drive pred_ready_o = (count != els_p) and res_ready_o = (count != 0), using registered state only; there is no bypass.
REQ-019 SHALL enqueue {pred_idx_i, pred_taken_i} when pred_v_i & pred_ready_o & ~flush_i; pred_v_i while full SHALL be dropped without changing state.
REQ-020 SHALL dequeue the head entry when res_v_i & res_ready_o; res_v_i while empty SHALL be ignored, with no update emitted.
REQ-021 SHALL register the update one cycle after the accepted resolution: w_v_o=1, idx_w_o=head idx, correct_o=(head taken == res_taken_i).
REQ-022 SHALL drive w_v_o=0 in every cycle with no accepted resolution; idx_w_o and correct_o SHALL hold their last values.
REQ-023 When enqueue and dequeue happen in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 A full queue with simultaneous res_v_i SHALL dequeue but reject pred_v_i, because ready is registered.
REQ-025 flush_i SHALL empty the queue at the next edge (count=0, pointers=0).
REQ-026 A resolution accepted in the same cycle as flush_i SHALL still emit its update.
REQ-027 An enqueue in the same cycle as flush_i SHALL be discarded.

Reset
REQ-028 SHALL on reset_i, at the next edge: set count=0 and both pointers=0; drive w_v_o=0, idx_w_o=0, correct_o=0 and mispredict_cnt_o=0.
REQ-029 Reset SHALL take priority over flush, enqueue and dequeue; an in-flight resolution in the reset cycle SHALL NOT produce an update.

Configuration
REQ-030 With macro BP_FE_BHT_UPDATER_STATS_EN defined, mispredict_cnt_o SHALL increment by 1 in each cycle where an update with correct=0 is registered, saturating at 16'hFFFF.
REQ-031 Without BP_FE_BHT_UPDATER_STATS_EN, mispredict_cnt_o SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-032 Enqueue (idx=5,taken=1), then res_taken=1 -> one cycle later w_v_o=1, idx_w_o=5, correct_o=1, then w_v_o=0.
REQ-033 Enqueue idx 1,2,3 (taken 0,1,0), then resolve 0,0,0 on consecutive cycles -> updates in order: idx 1 correct=1, idx 2 correct=0, idx 3 correct=1.
REQ-034 Fill els_p=8 entries -> pred_ready_o=0; a 9th pred_v_i is dropped; the same cycle's res_v_i dequeues, pred_ready_o=1 next cycle, and the drained order excludes the 9th.
REQ-035 Empty queue with res_v_i=1 -> res_ready_o=0, w_v_o stays 0, count stays 0.
REQ-036 3 entries, flush_i with res_v_i and pred_v_i in the same cycle -> one update for the head, count=0 next cycle, res_ready_o=0.
REQ-037 With STATS_EN, 3 mispredicted resolutions then reset mid-stream -> mispredict_cnt_o=3, then 0 after reset, w_v_o=0, count=0.
